// File: rtl/shift_mult_ctrl.sv
// Sequencing controller for a shift-and-add multiplier (Moore FSM driving ld/shift/add strobes).
// Optional feature: define SHIFT_MULT_EARLY_TERM_EN to finish as soon as the multiplier register is zero.
module shift_mult_ctrl #(
    parameter int unsigned N_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic lsb_in,
    input  logic mplr_zero,
    output logic ld_mcand,
    output logic ld_mplr,
    output logic shl_mcand,
    output logic shr_mplr,
    output logic acc_clr,
    output logic acc_ld,
    output logic busy,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(N_BITS) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        ADD,
        SHIFT,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               last_iter;

    assign last_iter = (cnt == CNT_W'(N_BITS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifndef SHIFT_MULT_EARLY_TERM_EN
    logic unused_mplr_zero;
    assign unused_mplr_zero = mplr_zero;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                cnt_nxt   = '0;
                state_nxt = CHECK;
            end
            CHECK: begin
`ifdef SHIFT_MULT_EARLY_TERM_EN
                // Accumulator is never shifted, so a zero multiplier means the product is final.
                if (mplr_zero) begin
                    state_nxt = DONE;
                end else if (lsb_in) begin
                    state_nxt = ADD;
                end else begin
                    state_nxt = SHIFT;
                end
`else
                state_nxt = lsb_in ? ADD : SHIFT;
`endif
            end
            ADD: begin
                state_nxt = SHIFT;
            end
            SHIFT: begin
                cnt_nxt   = cnt + CNT_W'(1);
                state_nxt = last_iter ? DONE : CHECK;
            end
            DONE: begin
                if (!start) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        ld_mcand  = 1'b0;
        ld_mplr   = 1'b0;
        shl_mcand = 1'b0;
        shr_mplr  = 1'b0;
        acc_clr   = 1'b0;
        acc_ld    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: ;
            LOAD: begin
                ld_mcand = 1'b1;
                ld_mplr  = 1'b1;
                acc_clr  = 1'b1;
                busy     = 1'b1;
            end
            CHECK: begin
                busy = 1'b1;
            end
            ADD: begin
                acc_ld = 1'b1;
                busy   = 1'b1;
            end
            SHIFT: begin
                shl_mcand = 1'b1;
                shr_mplr  = 1'b1;
                busy      = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_mult_ctrl.sv
// Directed bench for shift_mult_ctrl with a behavioural shift-and-add datapath alongside it.
// Expectations follow SHIFT_MULT_EARLY_TERM_EN when it is defined for the build.
module tb_shift_mult_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic lsb_in, mplr_zero;
    logic ld_mcand, ld_mplr, shl_mcand, shr_mplr, acc_clr, acc_ld, busy, done;

    int tests = 0;
    int fails = 0;

    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [31:0] m_mcand = '0;
    logic [15:0] m_mplr = '0;
    logic [31:0] m_acc = '0;
    logic [7:0]  outs;

    always #5 clk = ~clk;

    shift_mult_ctrl #(.N_BITS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lsb_in    (lsb_in),
        .mplr_zero (mplr_zero),
        .ld_mcand  (ld_mcand),
        .ld_mplr   (ld_mplr),
        .shl_mcand (shl_mcand),
        .shr_mplr  (shr_mplr),
        .acc_clr   (acc_clr),
        .acc_ld    (acc_ld),
        .busy      (busy),
        .done      (done)
    );

    assign outs      = {ld_mcand, ld_mplr, shl_mcand, shr_mplr, acc_clr, acc_ld, busy, done};
    assign lsb_in    = m_mplr[0];
    assign mplr_zero = (m_mplr == 16'h0000);

    always @(posedge clk) begin
        if (ld_mcand)  m_mcand <= {16'h0000, op_a};
        if (ld_mplr)   m_mplr  <= op_b;
        if (acc_clr)   m_acc   <= '0;
        else if (acc_ld) m_acc <= m_acc + m_mcand;
        if (shl_mcand) m_mcand <= m_mcand << 1;
        if (shr_mplr)  m_mplr  <= m_mplr >> 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after an edge with the FSM in IDLE; e0 is the next rising edge.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input bit tog,
                          input int exp_edges, input int exp_adds, input int exp_shifts,
                          input logic [15:0] exp_mask, input logic [31:0] exp_prod);
        int edges = 0;
        int adds = 0;
        int shifts = 0;
        logic [15:0] mask = '0;
        bit excl = 1'b1;
        bit load_ok = 1'b0;
        bit got = 1'b0;
        bit busy_done = 1'b0;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        while (edges < 100 && !got) begin
            @(posedge clk);
            #1;
            if (edges == 0)
                load_ok = ld_mcand && ld_mplr && acc_clr && busy && !done && !acc_ld && !shl_mcand && !shr_mplr;
            edges++;
            if (done) begin
                got = 1'b1;
                busy_done = !busy && !ld_mcand && !ld_mplr && !acc_ld && !shl_mcand;
            end else begin
                if (acc_ld) begin
                    adds++;
                    if (shifts < 16) mask[shifts] = 1'b1;
                end
                if (shl_mcand) shifts++;
                if (shl_mcand != shr_mplr) excl = 1'b0;
                if ((ld_mcand || ld_mplr || acc_clr) && (acc_ld || shl_mcand)) excl = 1'b0;
                if (acc_ld && shl_mcand) excl = 1'b0;
                if (!busy) excl = 1'b0;
                if (tog && shl_mcand) start = ~start;
            end
        end
        check({tag, " done_seen"}, 32'(got), 32'd1);
        check({tag, " load_cycle"}, 32'(load_ok), 32'd1);
        check({tag, " done_edge"}, 32'(edges - 1), 32'(exp_edges));
        check({tag, " add_count"}, 32'(adds), 32'(exp_adds));
        check({tag, " add_iters"}, 32'(mask), 32'(exp_mask));
        check({tag, " shift_count"}, 32'(shifts), 32'(exp_shifts));
        check({tag, " strobe_excl"}, 32'(excl), 32'd1);
        check({tag, " done_outs"}, 32'(busy_done), 32'd1);
        check({tag, " product"}, m_acc, exp_prod);
    endtask

    task automatic release_done(input string tag);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " idle_after_done"}, 32'(outs), 32'd0);
    endtask

    initial begin
        bit hit;
        int n;
        rst   = 1'b0;
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_outs", 32'(outs), 32'd0);
        end
        rst = 1'b1;

`ifdef SHIFT_MULT_EARLY_TERM_EN
        run_op("m3x5", 16'd3, 16'd5, 1'b0, 10, 2, 3, 16'h0005, 32'd15);
`else
        run_op("m3x5", 16'd3, 16'd5, 1'b0, 35, 2, 16, 16'h0005, 32'd15);
`endif
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_done", 32'(outs), 32'h0000_0001);
        end
        release_done("m3x5");

`ifdef SHIFT_MULT_EARLY_TERM_EN
        run_op("mplr0", 16'h00AB, 16'h0000, 1'b0, 2, 0, 0, 16'h0000, 32'd0);
`else
        run_op("mplr0", 16'h00AB, 16'h0000, 1'b0, 33, 0, 16, 16'h0000, 32'd0);
`endif
        release_done("mplr0");

        run_op("ffff", 16'hFFFF, 16'hFFFF, 1'b0, 49, 16, 16, 16'hFFFF, 32'hFFFE_0001);
        release_done("ffff");

        run_op("toggle", 16'h1234, 16'h8001, 1'b1, 35, 2, 16, 16'h8001, 32'h091A_1234);
        release_done("toggle");

        // Abort in the ADD of iteration 7 with a reset that does not line up with any edge.
        op_a  = 16'h00FF;
        op_b  = 16'hFFFF;
        start = 1'b1;
        hit   = 1'b0;
        n     = 0;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            @(posedge clk);
            #1;
            if (shl_mcand) n++;
            if (n == 7 && acc_ld) hit = 1'b1;
        end
        check("abort_reached_iter7", 32'(hit), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_outs_immediate", 32'(outs), 32'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_outs_held", 32'(outs), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_idle_after_release", 32'(outs), 32'd0);

`ifdef SHIFT_MULT_EARLY_TERM_EN
        run_op("m7x9", 16'd7, 16'd9, 1'b0, 12, 2, 4, 16'h0009, 32'd63);
`else
        run_op("m7x9", 16'd7, 16'd9, 1'b0, 35, 2, 16, 16'h0009, 32'd63);
`endif
        release_done("m7x9");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_mult_ctrl.md
Name: shift_mult_ctrl

Overview:
Sequencing controller for a shift-and-add multiplier built from 16-bit shift registers. The multiplicand register shifts left, the multiplier register shifts right, and an accumulator adds.
The controller accepts a start request and loads the operands. For each multiplier bit it inspects the multiplier LSB, optionally commands an add, then commands one shift on both registers. It signals done after the required number of iterations.
It sits beside the datapath in the same top level and drives all of the datapath's ld/shift/add strobes.

Parameters:
N_BITS, 16, number of multiplier bits (iterations); counter width is $clog2(N_BITS)+1.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets)
start  input  1  level request; sampled only in IDLE
lsb_in  input  1  multiplier register LSB_out
mplr_zero  input  1  multiplier register contents == 0 (used only with EARLY_TERM_EN)
ld_mcand  output  1  load multiplicand register
ld_mplr  output  1  load multiplier register
shl_mcand  output  1  shift multiplicand left one bit
shr_mplr  output  1  shift multiplier right one bit
acc_clr  output  1  clear accumulator
acc_ld  output  1  accumulator <= accumulator + multiplicand
busy  output  1  high in every state except IDLE and DONE
done  output  1  result valid

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst.
- Reset state: state=IDLE, bit counter=0, all outputs 0.
- Moore FSM. Outputs are decoded from the state register only; no output depends combinationally on inputs.
- IDLE: all strobes 0. If start=1 at an edge -> LOAD; else stay in IDLE.
- LOAD: one cycle. ld_mcand=ld_mplr=acc_clr=1; counter<=0. Next state CHECK.
- CHECK: all strobes 0. lsb_in=1 -> ADD; lsb_in=0 -> SHIFT.
- ADD: one cycle, acc_ld=1. Next state SHIFT.
- SHIFT: one cycle, shl_mcand=shr_mplr=1 (always asserted together; never with ld_* or acc_ld). Counter increments.
  - If the counter was N_BITS-1 -> DONE; else -> CHECK.
- DONE: done=1, busy=0. Stay in DONE while start=1; go to IDLE when start=0 (level handshake). done falls on the edge leaving DONE.
- Latency: edge e0 samples start. done is first high after edge e(33+k), where k = number of 1 bits in the 16-bit multiplier.
  - Minimum 33 edges (multiplier 0), maximum 49 edges (multiplier 0xFFFF).
- start is ignored in LOAD/CHECK/ADD/SHIFT; no restart or abort mid-operation.
- Reset mid-operation: immediate return to IDLE with all strobes 0. The datapath contents are don't-care.
- Counter never wraps: it is cleared in LOAD and the terminal compare uses N_BITS-1.
- At most one of {ld_*, acc_ld, shift} groups is active in any cycle.
- The datapath, not this block, is responsible for sizing the multiplicand/accumulator wide enough for a 2*N_BITS result.

Optional Feature:
SHIFT_MULT_EARLY_TERM_EN
- Defined: in CHECK, if mplr_zero=1 -> DONE directly, skipping the remaining iterations. The product is already complete because the accumulator is not shifted.
- Not defined: mplr_zero is ignored (port kept, unused) and exactly N_BITS iterations always run.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 -> all outputs 0, state IDLE. Release rst -> LOAD on the first edge with start=1.
- mcand=3, mplr=5 (k=2), macro off -> ld_* and acc_clr for 1 cycle; acc_ld pulses in iterations 0 and 2 only; 16 shift pulses; done after edge e35; accumulator=15.
- mplr=0x0000 -> acc_ld never asserted; done after e33. mplr=0xFFFF, mcand=0xFFFF -> 16 acc_ld pulses; done after e49; product 0xFFFE0001.
- Handshake: keep start=1 for 10 cycles after done -> done stays 1 and no new LOAD. Drop start -> IDLE next edge. Toggle start during SHIFT -> no effect.
- Reset mid-operation: assert rst=0 in iteration 7 -> strobes drop to 0 immediately. After release, start=1 runs a full new operation correctly.
- SHIFT_MULT_EARLY_TERM_EN defined, mplr=5 -> DONE after e10 (CHECK of iteration 3 sees mplr_zero=1); accumulator=15. With mplr=0 -> DONE after e2.
